// File: rtl/operand_forward_mux.sv
// operand_forward_mux
//   Execute-stage operand forwarding multiplexor. Picks one of num_src
//   operand sources (source 0 = register-file read value, others = later
//   pipeline stages) under control of the hazard unit, stalls while the
//   chosen producer is not ready, and registers the operand behind a
//   valid/ready handshake. Out-of-range selects yield a zero operand and
//   raise a sticky error flag.
//
// Ports
//   clk, reset_n  : rising-edge clock, asynchronous active-low reset
//   sig_control   : source select from the hazard unit
//   src_data      : flattened sources, source k at [k*size +: size]
//   src_ready     : per-source producer-ready flags
//   in_valid      : upstream instruction present
//   in_ready      : instruction accepted this cycle
//   result        : registered forwarded operand
//   out_valid     : result holds a valid operand
//   out_ready     : downstream consumes result this cycle
//   stall_req     : combinational load-use stall request
//   sel_err       : sticky out-of-range select flag
//   err_clr       : synchronous clear of sel_err (a coincident set wins)
//   stall_cnt     : saturating count of stall cycles
module operand_forward_mux #(
    parameter int unsigned size    = 32,
    parameter int unsigned num_src = 4,
    parameter int unsigned sel_w   = 2,
    parameter int unsigned cnt_w   = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [sel_w-1:0]          sig_control,
    input  logic [num_src*size-1:0]   src_data,
    input  logic [num_src-1:0]        src_ready,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [size-1:0]           result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      stall_req,
    output logic                      sel_err,
    input  logic                      err_clr,
    output logic [cnt_w-1:0]          stall_cnt
);

    // One extra bit so num_src == 2^sel_w is representable.
    localparam logic [sel_w:0] NSRC = (sel_w+1)'(num_src);

    logic              sel_ok;
    logic              sel_rdy;
    logic [size-1:0]   sel_dat;
    logic              src_ok;
    logic              accept;

    logic [size-1:0]   result_q, result_d;
    logic              out_valid_q, out_valid_d;
    logic              sel_err_q, sel_err_d;
    logic [cnt_w-1:0]  stall_cnt_q, stall_cnt_d;

    // Explicit decode over legal codes only: unused codes never index past
    // the source vectors and resolve to zero data / not-ready.
    always_comb begin
        sel_rdy = 1'b0;
        sel_dat = '0;
        for (int unsigned k = 0; k < num_src; k++) begin
            if (sig_control == sel_w'(k)) begin
                sel_rdy = src_ready[k];
                sel_dat = src_data[k*size +: size];
            end
        end
    end

    always_comb begin
        sel_ok    = ({1'b0, sig_control} < NSRC);
        src_ok    = sel_ok ? sel_rdy : 1'b1;
        stall_req = in_valid & sel_ok & ~sel_rdy;
        in_ready  = src_ok & (~out_valid_q | out_ready);
        accept    = in_valid & in_ready;
    end

    always_comb begin
        result_d    = result_q;
        out_valid_d = out_valid_q;
        sel_err_d   = sel_err_q;
        stall_cnt_d = stall_cnt_q;

        if (accept) begin
            result_d    = sel_ok ? sel_dat : '0;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept && !sel_ok) begin
            sel_err_d = 1'b1;
        end else if (err_clr) begin
            sel_err_d = 1'b0;
        end

        if (stall_req && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q    <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_forward_mux.sv
// Directed bench for operand_forward_mux: instance a uses the default
// parameters, instance b uses num_src=3 and cnt_w=4.
module tb_operand_forward_mux;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // instance a: size=32, num_src=4, sel_w=2, cnt_w=8
    logic [1:0]   a_sel;
    logic [127:0] a_src_data;
    logic [3:0]   a_src_ready;
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0]  a_result;
    logic         a_stall_req, a_sel_err, a_err_clr;
    logic [7:0]   a_stall_cnt;

    // instance b: size=32, num_src=3, sel_w=2, cnt_w=4
    logic [1:0]   b_sel;
    logic [95:0]  b_src_data;
    logic [2:0]   b_src_ready;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0]  b_result;
    logic         b_stall_req, b_sel_err, b_err_clr;
    logic [3:0]   b_stall_cnt;

    int total = 0;
    int bad   = 0;

    operand_forward_mux #(.size(32), .num_src(4), .sel_w(2), .cnt_w(8)) u_a (
        .clk(clk), .reset_n(reset_n), .sig_control(a_sel),
        .src_data(a_src_data), .src_ready(a_src_ready),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .result(a_result), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .stall_req(a_stall_req), .sel_err(a_sel_err), .err_clr(a_err_clr),
        .stall_cnt(a_stall_cnt)
    );

    operand_forward_mux #(.size(32), .num_src(3), .sel_w(2), .cnt_w(4)) u_b (
        .clk(clk), .reset_n(reset_n), .sig_control(b_sel),
        .src_data(b_src_data), .src_ready(b_src_ready),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .result(b_result), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .stall_req(b_stall_req), .sel_err(b_sel_err), .err_clr(b_err_clr),
        .stall_cnt(b_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        a_sel = 2'd0; a_src_data = '0; a_src_ready = '0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_err_clr = 1'b0;
        b_sel = 2'd0; b_src_data = '0; b_src_ready = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_err_clr = 1'b0;

        // ---------------- reset state
        tick(); tick();
        chk("rst_result",    a_result,    32'h0);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_sel_err",   32'(a_sel_err),   32'd0);
        chk("rst_stall_cnt", 32'(a_stall_cnt), 32'd0);
        reset_n = 1'b1;

        // ---------------- basic forwarding, full throughput
        a_src_data  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        a_src_ready = 4'hF;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_sel       = 2'd0;
        #1;
        chk("fwd_in_ready0", 32'(a_in_ready), 32'd1);
        tick();
        chk("fwd_res0", a_result, 32'h11111111);
        chk("fwd_ov0",  32'(a_out_valid), 32'd1);
        a_sel = 2'd1;
        tick();
        chk("fwd_res1", a_result, 32'h22222222);
        chk("fwd_ov1",  32'(a_out_valid), 32'd1);
        a_sel = 2'd2;
        tick();
        chk("fwd_res2", a_result, 32'h33333333);
        chk("fwd_ov2",  32'(a_out_valid), 32'd1);
        a_sel = 2'd3;
        tick();
        chk("fwd_res3", a_result, 32'h44444444);
        chk("fwd_ov3",  32'(a_out_valid), 32'd1);
        a_in_valid = 1'b0;
        tick();
        chk("drain_ov",  32'(a_out_valid), 32'd0);
        chk("drain_res", a_result, 32'h44444444);

        // ---------------- load-use stall, 3 cycles
        a_in_valid  = 1'b1;
        a_sel       = 2'd2;
        a_src_ready = 4'b1011;
        #1;
        chk("stall_req0", 32'(a_stall_req), 32'd1);
        chk("stall_inr0", 32'(a_in_ready),  32'd0);
        tick();
        chk("stall_req1", 32'(a_stall_req), 32'd1);
        chk("stall_inr1", 32'(a_in_ready),  32'd0);
        chk("stall_ov1",  32'(a_out_valid), 32'd0);
        tick();
        chk("stall_req2", 32'(a_stall_req), 32'd1);
        chk("stall_inr2", 32'(a_in_ready),  32'd0);
        tick();
        chk("stall_cnt3", 32'(a_stall_cnt), 32'd3);
        chk("stall_ov3",  32'(a_out_valid), 32'd0);
        a_src_ready = 4'hF;
        #1;
        chk("unstall_req", 32'(a_stall_req), 32'd0);
        chk("unstall_inr", 32'(a_in_ready),  32'd1);
        tick();
        chk("stall_acc_res", a_result, 32'h33333333);
        chk("stall_acc_ov",  32'(a_out_valid), 32'd1);
        chk("stall_cnt_hold", 32'(a_stall_cnt), 32'd3);

        // ---------------- backpressure: 4 cycles frozen, then drain+accept
        a_out_ready = 1'b0;
        a_sel       = 2'd1;
        #1;
        chk("bp_inr0", 32'(a_in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            // source data changes while held; only the accepting edge counts
            a_src_data[63:32] = 32'h50000000 + 32'(i);
            tick();
            chk("bp_res", a_result, 32'h33333333);
            chk("bp_ov",  32'(a_out_valid), 32'd1);
            chk("bp_inr", 32'(a_in_ready), 32'd0);
        end
        a_src_data[63:32] = 32'h55555555;
        a_out_ready = 1'b1;
        #1;
        chk("bp_rel_inr", 32'(a_in_ready), 32'd1);
        tick();
        chk("bp_rel_res", a_result, 32'h55555555);
        chk("bp_rel_ov",  32'(a_out_valid), 32'd1);
        a_in_valid = 1'b0;
        tick();
        chk("bp_drain_ov", 32'(a_out_valid), 32'd0);
        chk("a_no_err",    32'(a_sel_err),   32'd0);

        // ---------------- out-of-range select on b (num_src=3)
        b_src_data  = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        b_src_ready = 3'b111;
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_sel       = 2'd2;
        tick();
        chk("oor_pre_res", b_result, 32'hCCCCCCCC);
        chk("oor_pre_err", 32'(b_sel_err), 32'd0);
        b_sel = 2'd3;
        #1;
        chk("oor_inr",   32'(b_in_ready),  32'd1);
        chk("oor_stall", 32'(b_stall_req), 32'd0);
        tick();
        chk("oor_res", b_result, 32'h0);
        chk("oor_ov",  32'(b_out_valid), 32'd1);
        chk("oor_err", 32'(b_sel_err), 32'd1);
        b_in_valid = 1'b0;
        tick();
        chk("oor_err_held", 32'(b_sel_err), 32'd1);
        b_err_clr = 1'b1;
        tick();
        chk("oor_err_clr", 32'(b_sel_err), 32'd0);
        // clear and new error together; src_ready ignored for code 3
        b_in_valid  = 1'b1;
        b_src_ready = 3'b000;
        #1;
        chk("oor_rdy_ign_inr",   32'(b_in_ready),  32'd1);
        chk("oor_rdy_ign_stall", 32'(b_stall_req), 32'd0);
        tick();
        chk("oor_set_wins", 32'(b_sel_err), 32'd1);
        b_err_clr  = 1'b0;
        b_in_valid = 1'b0;
        tick();

        // ---------------- saturating stall counter (cnt_w=4)
        b_in_valid  = 1'b1;
        b_sel       = 2'd1;
        b_src_ready = 3'b101;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) chk("sat_cnt14", 32'(b_stall_cnt), 32'd14);
            if (i == 15) chk("sat_cnt15", 32'(b_stall_cnt), 32'd15);
        end
        chk("sat_cnt20", 32'(b_stall_cnt), 32'd15);
        chk("sat_req",   32'(b_stall_req), 32'd1);
        b_in_valid = 1'b0;

        // ---------------- asynchronous reset mid-cycle with a pending result
        a_in_valid  = 1'b1;
        a_sel       = 2'd0;
        a_out_ready = 1'b0;
        tick();
        chk("ar_pre_ov",  32'(a_out_valid), 32'd1);
        chk("ar_pre_res", a_result, 32'h11111111);
        a_in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_res",   a_result, 32'h0);
        chk("ar_ov",    32'(a_out_valid), 32'd0);
        chk("ar_cnt",   32'(a_stall_cnt), 32'd0);
        chk("ar_b_cnt", 32'(b_stall_cnt), 32'd0);
        chk("ar_b_err", 32'(b_sel_err),   32'd0);
        tick();
        reset_n = 1'b1;
        a_in_valid  = 1'b1;
        a_sel       = 2'd3;
        a_out_ready = 1'b1;
        tick();
        chk("ar_post_res", a_result, 32'h44444444);
        chk("ar_post_ov",  32'(a_out_valid), 32'd1);
        a_in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
